// File: rtl/uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// uart_rx : oversampled UART receiver, 7/8 data, 1/2 stop, none/even/odd parity
// Rev 1.0
// ============================================================================
module uart_rx #(
    parameter int DBITS         = 8,
    parameter int SBITS         = 2,
    parameter int SAMPLING_RATE = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_rx,
    input  logic             i_s_tick,
    input  logic             i_d_num,
    input  logic             i_s_num,
    input  logic [1:0]       i_par,
    output logic [DBITS-1:0] o_rx_data,
    output logic             o_rx_done,
    output logic             o_par_err,
    output logic             o_frm_err
);

    localparam int c_TW   = $clog2(SAMPLING_RATE);
    localparam int c_MAXB = (DBITS > SBITS) ? DBITS : SBITS;
    localparam int c_BW   = (c_MAXB > 1) ? $clog2(c_MAXB) : 1;

    localparam logic [c_TW-1:0] c_TICK_MID  = c_TW'(SAMPLING_RATE / 2 - 1);
    localparam logic [c_TW-1:0] c_TICK_LAST = c_TW'(SAMPLING_RATE - 1);
    localparam logic [c_BW-1:0] c_DATA_LAST_LONG  = c_BW'(DBITS - 1);
    localparam logic [c_BW-1:0] c_DATA_LAST_SHORT = c_BW'(DBITS - 2);
    localparam logic [c_BW-1:0] c_STOP_LAST_LONG  = c_BW'(SBITS - 1);
    localparam logic [c_BW-1:0] c_STOP_LAST_SHORT = '0;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP      = 3'd4,
        S_WAIT_IDLE = 3'd5
    } state_t;

    state_t            state_q;
    logic              rx_meta_q;
    logic              rx_s_q;
    logic [c_TW-1:0]   tcnt_q;
    logic [c_BW-1:0]   bcnt_q;
    logic [DBITS-1:0]  shreg_q;
    logic              d_num_q;
    logic              s_num_q;
    logic [1:0]        par_q;
    logic              perr_acc_q;
    logic              frm_acc_q;
    logic [DBITS-1:0]  rx_data_q;
    logic              rx_done_q;
    logic              par_err_q;
    logic              frm_err_q;

    logic              w_par_en;
    logic              w_bit_end;
    logic [c_BW-1:0]   w_data_last;
    logic [c_BW-1:0]   w_stop_last;
    logic              w_par_x;
    logic              frm_err_d;

    assign w_par_en    = (par_q == 2'b01) || (par_q == 2'b10);
    assign w_bit_end   = i_s_tick && (tcnt_q == c_TICK_LAST);
    assign w_data_last = d_num_q ? c_DATA_LAST_LONG : c_DATA_LAST_SHORT;
    assign w_stop_last = s_num_q ? c_STOP_LAST_LONG : c_STOP_LAST_SHORT;
    // Unused upper data bits stay 0 from the clear at start, so they drop out of the XOR.
    assign w_par_x     = (^shreg_q) ^ rx_s_q;
    assign frm_err_d   = frm_acc_q | ~rx_s_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= i_rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            tcnt_q     <= '0;
            bcnt_q     <= '0;
            shreg_q    <= '0;
            d_num_q    <= 1'b0;
            s_num_q    <= 1'b0;
            par_q      <= 2'b00;
            perr_acc_q <= 1'b0;
            frm_acc_q  <= 1'b0;
            rx_data_q  <= '0;
            rx_done_q  <= 1'b0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
        end else begin
            rx_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!rx_s_q) begin
                        state_q    <= S_START;
                        tcnt_q     <= '0;
                        bcnt_q     <= '0;
                        shreg_q    <= '0;
                        perr_acc_q <= 1'b0;
                        frm_acc_q  <= 1'b0;
                        d_num_q    <= i_d_num;
                        s_num_q    <= i_s_num;
                        par_q      <= i_par;
                    end
                end

                S_START: begin
                    if (i_s_tick) begin
                        if (tcnt_q == c_TICK_MID) begin
                            tcnt_q  <= '0;
                            state_q <= rx_s_q ? S_IDLE : S_DATA;
                        end else begin
                            tcnt_q <= tcnt_q + 1'b1;
                        end
                    end
                end

                S_DATA: begin
                    if (w_bit_end) begin
                        tcnt_q          <= '0;
                        shreg_q[bcnt_q] <= rx_s_q;
                        if (bcnt_q == w_data_last) begin
                            bcnt_q  <= '0;
                            state_q <= w_par_en ? S_PARITY : S_STOP;
                        end else begin
                            bcnt_q <= bcnt_q + 1'b1;
                        end
                    end else if (i_s_tick) begin
                        tcnt_q <= tcnt_q + 1'b1;
                    end
                end

                S_PARITY: begin
                    if (w_bit_end) begin
                        tcnt_q     <= '0;
                        perr_acc_q <= (par_q == 2'b01) ? w_par_x : ~w_par_x;
                        state_q    <= S_STOP;
                    end else if (i_s_tick) begin
                        tcnt_q <= tcnt_q + 1'b1;
                    end
                end

                S_STOP: begin
                    if (w_bit_end) begin
                        tcnt_q    <= '0;
                        frm_acc_q <= frm_err_d;
                        if (bcnt_q == w_stop_last) begin
                            // Leave at mid-stop so a following start edge is not missed.
                            rx_done_q <= 1'b1;
                            rx_data_q <= shreg_q;
                            par_err_q <= w_par_en & perr_acc_q;
                            frm_err_q <= frm_err_d;
                            bcnt_q    <= '0;
                            state_q   <= rx_s_q ? S_IDLE : S_WAIT_IDLE;
                        end else begin
                            bcnt_q <= bcnt_q + 1'b1;
                        end
                    end else if (i_s_tick) begin
                        tcnt_q <= tcnt_q + 1'b1;
                    end
                end

                S_WAIT_IDLE: begin
                    if (rx_s_q) begin
                        state_q <= S_IDLE;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_rx_data = rx_data_q;
    assign o_rx_done = rx_done_q;
    assign o_par_err = par_err_q;
    assign o_frm_err = frm_err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_uart_rx : directed table, corner sequences and random frames vs a line decoder model
// Rev 1.0
// ============================================================================
module tb_uart_rx;

    localparam int SR  = 16;
    localparam int DIV = 3;

    logic       i_clk   = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_rx    = 1'b1;
    logic       i_s_tick = 1'b0;
    logic       i_d_num = 1'b1;
    logic       i_s_num = 1'b0;
    logic [1:0] i_par   = 2'b00;
    logic [7:0] o_rx_data;
    logic       o_rx_done;
    logic       o_par_err;
    logic       o_frm_err;

    uart_rx #(.DBITS(8), .SBITS(2), .SAMPLING_RATE(SR)) dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_rx      (i_rx),
        .i_s_tick  (i_s_tick),
        .i_d_num   (i_d_num),
        .i_s_num   (i_s_num),
        .i_par     (i_par),
        .o_rx_data (o_rx_data),
        .o_rx_done (o_rx_done),
        .o_par_err (o_par_err),
        .o_frm_err (o_frm_err)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    typedef struct {
        bit       dn;
        bit       sn;
        bit [1:0] par;
        bit [7:0] data;
        bit       flip;
        bit [1:0] bad;
        int       gap;
        bit [7:0] exp_data;
        bit       exp_perr;
        bit       exp_ferr;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    int   tick_in_bit = 0;
    int   cur_bit = -1;
    int   last_bit = 0;
    bit   check_timing = 1'b0;
    exp_t exp_q[$];
    bit   fbits[$];
    vec_t tbl[11];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    initial begin
        int div;
        div = 0;
        forever begin
            @(negedge i_clk);
            div = (div == DIV - 1) ? 0 : div + 1;
            i_s_tick = (div == 0);
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge i_clk);
            if (o_rx_done) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got data 0x%0h required no done", o_rx_data);
                end else begin
                    e = exp_q.pop_front();
                    check("rx_data", int'(o_rx_data), int'(e.data));
                    check("par_err", int'(o_par_err), int'(e.perr));
                    check("frm_err", int'(o_frm_err), int'(e.ferr));
                end
                if (check_timing) begin
                    check("done_in_last_stop_bit", cur_bit, last_bit);
                    check("done_at_mid_stop", int'(tick_in_bit >= 8 && tick_in_bit <= 10), 1);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic wait_tick();
        do @(posedge i_clk); while (i_s_tick !== 1'b1);
        tick_in_bit++;
    endtask

    task automatic idle_bits(input int n);
        @(negedge i_clk);
        i_rx = 1'b1;
        cur_bit = -1;
        repeat (n * SR) wait_tick();
    endtask

    // Line-level frame image: start, data LSB first, optional parity, stop bits.
    task automatic build_frame(input bit dn, input bit sn, input bit [1:0] par,
                               input bit [7:0] data, input bit flip, input bit [1:0] bad);
        int nd;
        bit p;
        fbits.delete();
        fbits.push_back(1'b0);
        nd = dn ? 8 : 7;
        p = 1'b0;
        for (int i = 0; i < nd; i++) begin
            fbits.push_back(data[i]);
            p ^= data[i];
        end
        if (par == 2'b01 || par == 2'b10)
            fbits.push_back(((par == 2'b10) ? ~p : p) ^ flip);
        for (int k = 0; k < (sn ? 2 : 1); k++)
            fbits.push_back(~bad[k]);
    endtask

    // Reference receiver: reads the frame image back using the protocol rules.
    function automatic exp_t decode(input bit dn, input bit sn, input bit [1:0] par);
        exp_t e;
        int idx, ones, nd;
        e = '0;
        nd = dn ? 8 : 7;
        idx = 1;
        ones = 0;
        for (int i = 0; i < nd; i++) begin
            e.data[i] = fbits[idx];
            ones += int'(fbits[idx]);
            idx++;
        end
        if (par == 2'b01 || par == 2'b10) begin
            ones += int'(fbits[idx]);
            e.perr = (par == 2'b01) ? (ones % 2 == 1) : (ones % 2 == 0);
            idx++;
        end
        for (int k = 0; k < (sn ? 2 : 1); k++)
            if (!fbits[idx + k]) e.ferr = 1'b1;
        return e;
    endfunction

    task automatic send_frame(input bit dn, input bit sn, input bit [1:0] par,
                              input bit scramble, input int nbits);
        last_bit = fbits.size() - 1;
        for (int b = 0; b < nbits; b++) begin
            @(negedge i_clk);
            if (b == 0) begin
                i_d_num = dn;
                i_s_num = sn;
                i_par   = par;
            end
            i_rx = fbits[b];
            cur_bit = b;
            tick_in_bit = 0;
            for (int t = 0; t < SR; t++) begin
                wait_tick();
                if (scramble && b == 0 && t == 4) begin
                    i_d_num = 1'($urandom);
                    i_s_num = 1'($urandom);
                    i_par   = 2'($urandom);
                end
            end
        end
    endtask

    initial begin
        exp_t       e;
        int         base;
        logic [7:0] hold_data;
        logic       hold_perr, hold_ferr;
        bit         dn, sn, flip;
        bit [1:0]   par, bad;
        bit [7:0]   data;
        int         gap;

        //           dn    sn    par    data   flip  bad    gap exp   perr  ferr
        tbl[0]  = '{1'b1, 1'b0, 2'b00, 8'hA5, 1'b0, 2'b00, 0, 8'hA5, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 2'b01, 8'h53, 1'b0, 2'b00, 0, 8'h53, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 2'b01, 8'h53, 1'b1, 2'b00, 0, 8'h53, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 2'b10, 8'h00, 1'b0, 2'b00, 0, 8'h00, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 2'b10, 8'hFF, 1'b0, 2'b00, 0, 8'hFF, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 2'b01, 8'h0F, 1'b0, 2'b01, 1, 8'h0F, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 2'b00, 8'hFF, 1'b0, 2'b00, 0, 8'h7F, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 2'b00, 8'h5A, 1'b0, 2'b10, 1, 8'h5A, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 1'b1, 2'b10, 8'h2A, 1'b1, 2'b00, 0, 8'h2A, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 2'b11, 8'hC3, 1'b0, 2'b00, 0, 8'hC3, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 2'b00, 8'h96, 1'b0, 2'b01, 0, 8'h96, 1'b0, 1'b1};

        repeat (4) @(negedge i_clk);
        check("reset_rx_data", int'(o_rx_data), 0);
        check("reset_rx_done", int'(o_rx_done), 0);
        check("reset_par_err", int'(o_par_err), 0);
        check("reset_frm_err", int'(o_frm_err), 0);
        i_rst_n = 1'b1;
        idle_bits(1);

        for (int r = 0; r < 11; r++) begin
            build_frame(tbl[r].dn, tbl[r].sn, tbl[r].par, tbl[r].data, tbl[r].flip, tbl[r].bad);
            e.data = tbl[r].exp_data;
            e.perr = tbl[r].exp_perr;
            e.ferr = tbl[r].exp_ferr;
            exp_q.push_back(e);
            check_timing = (r == 0);
            send_frame(tbl[r].dn, tbl[r].sn, tbl[r].par, 1'b0, fbits.size());
            check_timing = 1'b0;
            if (tbl[r].gap > 0) idle_bits(tbl[r].gap);
        end
        idle_bits(1);
        check("table_done_count", done_cnt, 11);

        // Short low glitch: must be rejected as a false start.
        base = done_cnt;
        hold_data = o_rx_data;
        hold_perr = o_par_err;
        hold_ferr = o_frm_err;
        @(negedge i_clk);
        i_rx = 1'b0;
        repeat (5) wait_tick();
        idle_bits(3);
        check("glitch_no_done", done_cnt, base);
        check("glitch_hold_data", int'(o_rx_data), int'(hold_data));
        check("glitch_hold_perr", int'(o_par_err), int'(hold_perr));
        check("glitch_hold_ferr", int'(o_frm_err), int'(hold_ferr));

        // Break: three 8N1 frame times low gives exactly one errored frame.
        base = done_cnt;
        e = '{data: 8'h00, perr: 1'b0, ferr: 1'b1};
        exp_q.push_back(e);
        @(negedge i_clk);
        i_d_num = 1'b1;
        i_s_num = 1'b0;
        i_par   = 2'b00;
        i_rx    = 1'b0;
        repeat (3 * 10 * SR) wait_tick();
        check("break_single_done", done_cnt - base, 1);
        idle_bits(2);
        check("break_no_more_done", done_cnt - base, 1);
        build_frame(1'b1, 1'b0, 2'b00, 8'h3C, 1'b0, 2'b00);
        exp_q.push_back(decode(1'b1, 1'b0, 2'b00));
        send_frame(1'b1, 1'b0, 2'b00, 1'b0, fbits.size());
        idle_bits(1);
        check("after_break_done", done_cnt - base, 2);

        // Reset in the middle of the data bits of 0x81.
        base = done_cnt;
        build_frame(1'b1, 1'b0, 2'b00, 8'h81, 1'b0, 2'b00);
        send_frame(1'b1, 1'b0, 2'b00, 1'b0, 4);
        @(negedge i_clk);
        i_rst_n = 1'b0;
        #1;
        check("midreset_rx_data", int'(o_rx_data), 0);
        check("midreset_rx_done", int'(o_rx_done), 0);
        check("midreset_par_err", int'(o_par_err), 0);
        check("midreset_frm_err", int'(o_frm_err), 0);
        i_rx = 1'b1;
        repeat (5) @(negedge i_clk);
        i_rst_n = 1'b1;
        idle_bits(2);
        check("midreset_no_done", done_cnt, base);
        build_frame(1'b1, 1'b0, 2'b00, 8'h7E, 1'b0, 2'b00);
        exp_q.push_back(decode(1'b1, 1'b0, 2'b00));
        send_frame(1'b1, 1'b0, 2'b00, 1'b0, fbits.size());
        idle_bits(1);
        check("after_reset_done", done_cnt - base, 1);

        // Random frames, config inputs scrambled after the start edge.
        base = done_cnt;
        for (int n = 0; n < 40; n++) begin
            dn   = 1'($urandom);
            sn   = 1'($urandom);
            par  = 2'($urandom);
            data = 8'($urandom);
            flip = ($urandom_range(0, 3) == 0);
            bad  = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            build_frame(dn, sn, par, data, flip, bad);
            exp_q.push_back(decode(dn, sn, par));
            send_frame(dn, sn, par, 1'b1, fbits.size());
            gap = (bad[sn ? 1 : 0]) ? 1 : int'($urandom_range(0, 1));
            if (gap > 0) idle_bits(gap);
        end
        idle_bits(1);
        check("random_done_count", done_cnt - base, 40);
        check("expect_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
